// File: rtl/mp3_playlist_ctrl_pkg.sv
// Shared types and constants for the MP3 playlist controller: state encoding,
// play-mode encodings, per-track word counts and track-id step helpers.
package mp3_playlist_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  localparam logic [1:0] MODE_SEQ     = 2'b00;
  localparam logic [1:0] MODE_REPEAT  = 2'b01;
  localparam logic [1:0] MODE_SHUFFLE = 2'b10;

  // Word count of each ROM image, indexed by track id.
  localparam logic [16:0] TRACK_LEN [16] = '{
    17'd6, 17'd5, 17'd3, 17'd7, 17'd4, 17'd8, 17'd8, 17'd8,
    17'd8, 17'd8, 17'd8, 17'd8, 17'd8, 17'd8, 17'd8, 17'd8
  };

  // 5-bit intermediates so that id+1 at 15 cannot wrap silently in 4 bits.
  function automatic logic [3:0] id_inc(input logic [3:0] id, input logic [4:0] n);
    logic [4:0] t;
    t = {1'b0, id} + 5'd1;
    if (t >= n) begin
      t = 5'd0;
    end else begin
      t = t;
    end
    return t[3:0];
  endfunction

  function automatic logic [3:0] id_dec(input logic [3:0] id, input logic [4:0] n);
    logic [4:0] t;
    if (id == 4'd0) begin
      t = n - 5'd1;
    end else begin
      t = {1'b0, id} - 5'd1;
    end
    return t[3:0];
  endfunction

endpackage

// File: rtl/mp3_playlist_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick shuffle tracks.
module mp3_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Next LFSR state; a non-zero state never maps to zero.
  always_comb begin
    q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  // LFSR register, reloaded with the seed on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mp3_playlist_ctrl.sv
// Playlist controller: play/pause/skip handling, end-of-track detection,
// inter-track gap timing and next-track selection for an MP3 player.
module mp3_playlist_ctrl
  import mp3_playlist_ctrl_pkg::*;
#(
  parameter int         NUM_TRACKS = 5,
  parameter int         GAP_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_play,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic [1:0]  mode,
  input  logic        word_done,
  output logic [3:0]  music_id,
  output logic        play,
  output logic        switching,
  output logic [16:0] words_played
);

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    NT5      = 5'(NUM_TRACKS);
  localparam logic [7:0]    NT8      = 8'(NUM_TRACKS);

  state_e        state_q, state_d;
  logic [3:0]    music_id_q, music_id_d;
  logic          play_q, play_d;
  logic          switching_q, switching_d;
  logic [16:0]   words_played_q, words_played_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    lfsr_s;
  logic [3:0]    shuf_id_s;
  logic [3:0]    auto_id_s;
  logic          eot_s;

  mp3_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_s)
  );

  // Id chosen automatically at end of track, according to the play mode.
  always_comb begin
    shuf_id_s = 4'(lfsr_s % NT8);
    eot_s     = (words_played_q >= (TRACK_LEN[music_id_q] - 17'd1));
    case (mode)
      MODE_REPEAT:  auto_id_s = music_id_q;
      MODE_SHUFFLE: begin
        if (shuf_id_s == music_id_q) begin
          auto_id_s = id_inc(music_id_q, NT5);
        end else begin
          auto_id_s = shuf_id_s;
        end
      end
      default:      auto_id_s = id_inc(music_id_q, NT5);
    endcase
  end

  // Next-state logic; buttons are prioritised play > next > prev > word_done.
  always_comb begin
    state_d        = state_q;
    music_id_d     = music_id_q;
    words_played_d = words_played_q;
    gap_cnt_d      = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_play) begin
          state_d = ST_PLAYING;
        end else if (btn_next) begin
          music_id_d = id_inc(music_id_q, NT5);
        end else if (btn_prev) begin
          music_id_d = id_dec(music_id_q, NT5);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAYING: begin
        if (btn_play) begin
          state_d = ST_PAUSED;
        end else if (btn_next || btn_prev || (word_done && eot_s)) begin
          state_d        = ST_GAP;
          words_played_d = 17'd0;
          gap_cnt_d      = '0;
          if (btn_next) begin
            music_id_d = id_inc(music_id_q, NT5);
          end else if (btn_prev) begin
            music_id_d = id_dec(music_id_q, NT5);
          end else begin
            music_id_d = auto_id_s;
          end
        end else if (word_done && (words_played_q != 17'h1FFFF)) begin
          words_played_d = words_played_q + 17'd1;
        end else begin
          words_played_d = words_played_q;
        end
      end
      ST_PAUSED: begin
        if (btn_play) begin
          state_d = ST_PLAYING;
        end else if (btn_next || btn_prev) begin
          state_d        = ST_GAP;
          words_played_d = 17'd0;
          gap_cnt_d      = '0;
          music_id_d     = btn_next ? id_inc(music_id_q, NT5) : id_dec(music_id_q, NT5);
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_PLAYING;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    play_d      = (state_d == ST_PLAYING);
    switching_d = (state_d == ST_GAP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      music_id_q     <= 4'd0;
      play_q         <= 1'b0;
      switching_q    <= 1'b0;
      words_played_q <= 17'd0;
      gap_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      music_id_q     <= music_id_d;
      play_q         <= play_d;
      switching_q    <= switching_d;
      words_played_q <= words_played_d;
      gap_cnt_q      <= gap_cnt_d;
    end
  end

  assign music_id     = music_id_q;
  assign play         = play_q;
  assign switching    = switching_q;
  assign words_played = words_played_q;

endmodule

// File: tb/tb_mp3_playlist_ctrl.sv
// Scoreboard bench for mp3_playlist_ctrl: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them and checks shuffle picks.
module tb_mp3_playlist_ctrl;

  typedef struct {
    int    tgt;
    string nm;
    int    id;
    bit    p;
    bit    sw;
    int    w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_play = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, word_done = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  music_id;
  logic        play, switching;
  logic [16:0] words_played;

  exp_t  sbq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    shuf_ends = 0;
  bit    shuf_chk = 1'b0;
  bit    req_fail = 1'b0;
  string req_nm = "";
  bit    prev_sw = 1'b0;
  logic [3:0] prev_id = 4'd0;

  mp3_playlist_ctrl #(.NUM_TRACKS(5), .GAP_CYCLES(16), .LFSR_SEED(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_play     (btn_play),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .mode         (mode),
    .word_done    (word_done),
    .music_id     (music_id),
    .play         (play),
    .switching    (switching),
    .words_played (words_played)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares queued expectations and shuffle picks away from the edge.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
      e = sbq.pop_front();
      n_checks++;
      if (e.tgt != cyc || music_id != 4'(e.id) || play != e.p ||
          switching != e.sw || words_played != 17'(e.w)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got id=%0d play=%0b sw=%0b words=%0d need id=%0d play=%0b sw=%0b words=%0d",
                 e.nm, cyc, music_id, play, switching, words_played, e.id, e.p, e.sw, e.w);
      end
    end
    if (shuf_chk && switching && !prev_sw) begin
      n_checks++;
      shuf_ends++;
      if (music_id > 4'd4 || music_id == prev_id) begin
        n_fail++;
        $display("FAIL shuffle_pick end=%0d got id=%0d prev id=%0d need id in 0..4 and not prev",
                 shuf_ends, music_id, prev_id);
      end
    end
    if (req_fail) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s got timeout need completion", req_nm);
      req_fail = 1'b0;
    end
    prev_sw = switching;
    prev_id = music_id;
  end

  task automatic step(input bit bp, input bit bn, input bit bpr, input bit wd,
                      input string nm, input int id, input bit p, input bit sw, input int w);
    exp_t e;
    e.tgt = cyc + 1; e.nm = nm; e.id = id; e.p = p; e.sw = sw; e.w = w;
    sbq.push_back(e);
    btn_play = bp; btn_next = bn; btn_prev = bpr; word_done = wd;
    @(negedge clk);
    btn_play = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; word_done = 1'b0;
  endtask

  // Remaining 15 gap cycles (with ignored buttons/words) then resume playing.
  task automatic gap_run(input int id);
    for (int i = 0; i < 15; i++)
      step(i == 2, i == 3, i == 4, i == 5, "gap_hold", id, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, "gap_exit", id, 1'b1, 1'b0, 0);
  endtask

  initial begin
    @(negedge clk);
    step(0, 0, 0, 0, "reset", 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 1, 0, "prev_wrap", 4, 0, 0, 0);
    step(0, 1, 0, 0, "next_wrap", 0, 0, 0, 0);
    step(1, 0, 0, 0, "play_start", 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 1, "words_count", 0, 1, 0, i);
    step(1, 1, 0, 0, "pause_prio", 0, 0, 0, 3);
    step(0, 0, 0, 1, "paused_word", 0, 0, 0, 3);
    step(0, 0, 1, 0, "paused_prev", 4, 0, 1, 0);
    gap_run(4);
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 1, "t4_words", 4, 1, 0, i);
    step(0, 0, 0, 1, "seq_eot_wrap", 0, 0, 1, 0);
    gap_run(0);
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, "t0_words", 0, 1, 0, i);
    step(0, 1, 0, 1, "next_at_eot", 1, 0, 1, 0);
    gap_run(1);
    mode = 2'b01;
    step(0, 1, 0, 0, "rep_next", 2, 0, 1, 0);
    gap_run(2);
    for (int i = 1; i <= 2; i++) step(0, 0, 0, 1, "t2_words", 2, 1, 0, i);
    step(0, 0, 0, 1, "rep_eot", 2, 0, 1, 0);
    gap_run(2);
    step(0, 0, 1, 0, "rep_prev", 1, 0, 1, 0);
    gap_run(1);
    mode = 2'b11;
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, "t1_words", 1, 1, 0, i);
    step(0, 0, 0, 1, "mode11_eot", 2, 0, 1, 0);
    gap_run(2);

    mode = 2'b10;
    shuf_chk = 1'b1;
    for (int k = 0; k < 3000 && shuf_ends < 50; k++) begin
      word_done = play && !switching;
      @(negedge clk);
      word_done = 1'b0;
    end
    shuf_chk = 1'b0;
    if (shuf_ends < 50) begin
      req_nm = "shuffle_budget";
      req_fail = 1'b1;
      @(negedge clk);
    end
    mode = 2'b00;

    rst = 1'b0;
    step(0, 0, 0, 0, "reset_any", 0, 0, 0, 0);
    rst = 1'b1;
    step(1, 0, 0, 0, "replay", 0, 1, 0, 0);
    step(0, 1, 0, 0, "gap_c1", 1, 0, 1, 0);
    for (int i = 2; i <= 5; i++) step(0, 0, 0, 0, "gap_c2to5", 1, 0, 1, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, "reset_mid_gap", 0, 0, 0, 0);
    step(0, 0, 0, 0, "reset_hold", 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, "post_reset_idle", 0, 0, 0, 0);
    step(1, 0, 0, 0, "post_reset_play", 0, 1, 0, 0);

    for (int k = 0; k < 40 && sbq.size() > 0; k++) @(negedge clk);
    if (sbq.size() > 0) begin
      req_nm = "scoreboard_drain";
      req_fail = 1'b1;
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
